arb_wrr_4: RTL
==============

Name: arb_wrr_4

Overview:
- 4-client weighted round-robin arbiter sharing one data_mem port.
- Each client posts a request: addr, read/write, wdata, tag. The granted client keeps ownership for up to cfg_weight_<i> consecutive accepted transactions, then ownership rotates.
- Read returns come back in order and are routed to the issuing client through an internal ID FIFO.
- Drop-in superset of arb_rr_2 for benches and subsystems with more than two masters.

Parameters:
- W, 16, data width
- AW, 10, address width
- TW, 4, tag width
- QW, 4, weight/quota counter width
- RD, 4, max outstanding reads (ID FIFO depth, power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- client_req_<i> (i=0..3)  in  1  request valid
- client_addr_<i>  in  AW  address
- client_read_<i>  in  1  1=read, 0=write
- client_wdata_<i>  in  W  write data
- client_tag_<i>  in  TW  user tag, passed to memory
- client_bsy_<i>  out  1  request not accepted this cycle
- client_rvalid_<i>  out  1  read data valid for client i
- client_rdata_<i>  out  W  read data (broadcast of mem_rdata)
- cfg_weight_<i>  in  QW  quota per turn; 0 treated as 1
- mem_req  out  1  registered request valid
- mem_addr  out  AW  registered address
- mem_read  out  1  registered read flag
- mem_wdata  out  W  registered write data
- mem_tag  out  TW  registered tag
- mem_bsy  in  1  memory stall
- mem_rvalid  in  1  read return valid (in order)
- mem_rdata  in  W  read return data

Behaviour:
- Reset values:
  - mem_req=0; mem_addr, mem_wdata, mem_tag, mem_read = 0.
  - client_rvalid_*=0.
  - owner=3, so the first search starts at client 0. cnt=0.
  - ID FIFO empty.
- Slot free: slot_free = ~mem_req | ~mem_bsy.
- Selection (combinational, from registered state):
  - If client_req_owner=1 and cnt < max(cfg_weight_owner,1), then sel=owner.
  - Otherwise sel is the first requesting client scanning owner+1, owner+2, … modulo 4, wrapping back to owner last.
- Acceptance of client i:
  - Condition: client_req_i & sel==i & slot_free & ~(client_read_i & rdq_full).
  - client_bsy_i = ~acceptance condition, for every i. Non-selected clients always see bsy=1.
  - No combinational path from client_req_* to client_bsy_* of the same client beyond sel.
- On accept:
  - mem_* loads the client fields next cycle, so latency is 1 cycle from accept to mem_req.
  - If sel==owner and cnt was not exhausted: cnt <= cnt+1. Otherwise owner <= sel and cnt <= 1.
  - Read accept pushes sel into the ID FIFO.
- Memory handshake:
  - Without an accept, mem_req clears when ~mem_bsy.
  - While mem_bsy=1, mem_* hold stable.
- No requests: owner and cnt hold. The quota is not refreshed until rotation or wrap.
- Single requester: rotation search wraps to the same client with cnt=1. Back-to-back service continues with no bubble.
- Owner drops req mid-quota: ownership moves on immediately (work-conserving). The remaining quota is forfeited.
- cfg_weight changes take effect at the next comparison. Lowering below cnt ends the turn.
- Read return:
  - mem_rvalid pops the FIFO head h. client_rvalid_h=1 in the same cycle, combinational from mem_rvalid.
  - mem_rvalid with the FIFO empty is an error. It is ignored and no rvalid is raised.
- rdq_full comes from the registered count only. A simultaneous pop does not free a push slot that cycle.
- Writes never consume FIFO entries.
- Reset mid-operation clears all state. In-flight reads are discarded and later returns are ignored as above.

Optional Feature:
- Macro: ARB_WRR_STATS_EN.
- When defined, adds outputs stat_grant_<i> (16b), one per client.
  - Saturating count of accepted transactions; holds at 16'hFFFF.
  - Cleared by rst or by a new input stat_clr (1b, synchronous, priority over increment).
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- All 4 clients request continuously, all weights=1, mem_bsy=0 → grants 0,1,2,3,0,… one per cycle; mem_req high every cycle after the first.
- Weights {3,1,2,1}, all requesting → accepted order 0,0,0,1,2,2,3 repeating; each client_bsy low only in its slots.
- mem_bsy held high 5 cycles with mem_req=1 → mem_* stable; all client_bsy=1; the stalled transaction transfers on the first cycle mem_bsy=0.
- Clients 1 and 3 issue 4 reads each (RD=4) with no returns → 5th read is blocked (bsy=1) until mem_rvalid; returns routed in issue order to the matching client_rvalid_*.
- Only client 2 requests, weight=2, then client 0 joins mid-turn → client 2 finishes its quota, then client 0; with weight=0, client 2 gets exactly 1 per turn.
- rst pulsed while 2 reads are outstanding and mem_req=1 → all outputs 0 the same cycle; subsequent mem_rvalid raises no client_rvalid_*.

Source files
------------

// File: rtl/arb_wrr_4.sv
`default_nettype none
// ============================================================================
// Module   : arb_wrr_4
// Purpose  : 4-client weighted round-robin arbiter in front of a single
//            data_mem port. The owning client may issue up to
//            max(cfg_weight_<i>,1) consecutive accepted transactions before
//            ownership rotates. Read returns arrive in order and are steered
//            back to the issuing client through an internal ID FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   client_req_<i>           request valid            (i = 0..3)
//   client_addr_<i>          request address          [AW]
//   client_read_<i>          1 = read, 0 = write
//   client_wdata_<i>         write data               [W]
//   client_tag_<i>           user tag to memory       [TW]
//   client_bsy_<i>           request not accepted this cycle
//   client_rvalid_<i>        read data valid for client i
//   client_rdata_<i>         read data (mem_rdata broadcast) [W]
//   cfg_weight_<i>           quota per turn, 0 behaves as 1  [QW]
//   mem_req/addr/read/wdata/tag  registered memory request
//   mem_bsy                  memory stall
//   mem_rvalid, mem_rdata    in-order read return
// Optional (macro ARB_WRR_STATS_EN)
//   stat_clr                 synchronous clear of the grant counters
//   stat_grant_<i>           saturating accepted-transaction count [16]
// ============================================================================
module arb_wrr_4 #(
    parameter int W  = 16,
    parameter int AW = 10,
    parameter int TW = 4,
    parameter int QW = 4,
    parameter int RD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          client_req_0,
    input  logic          client_req_1,
    input  logic          client_req_2,
    input  logic          client_req_3,
    input  logic [AW-1:0] client_addr_0,
    input  logic [AW-1:0] client_addr_1,
    input  logic [AW-1:0] client_addr_2,
    input  logic [AW-1:0] client_addr_3,
    input  logic          client_read_0,
    input  logic          client_read_1,
    input  logic          client_read_2,
    input  logic          client_read_3,
    input  logic [W-1:0]  client_wdata_0,
    input  logic [W-1:0]  client_wdata_1,
    input  logic [W-1:0]  client_wdata_2,
    input  logic [W-1:0]  client_wdata_3,
    input  logic [TW-1:0] client_tag_0,
    input  logic [TW-1:0] client_tag_1,
    input  logic [TW-1:0] client_tag_2,
    input  logic [TW-1:0] client_tag_3,
    output logic          client_bsy_0,
    output logic          client_bsy_1,
    output logic          client_bsy_2,
    output logic          client_bsy_3,
    output logic          client_rvalid_0,
    output logic          client_rvalid_1,
    output logic          client_rvalid_2,
    output logic          client_rvalid_3,
    output logic [W-1:0]  client_rdata_0,
    output logic [W-1:0]  client_rdata_1,
    output logic [W-1:0]  client_rdata_2,
    output logic [W-1:0]  client_rdata_3,
    input  logic [QW-1:0] cfg_weight_0,
    input  logic [QW-1:0] cfg_weight_1,
    input  logic [QW-1:0] cfg_weight_2,
    input  logic [QW-1:0] cfg_weight_3,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic [W-1:0]  mem_wdata,
    output logic [TW-1:0] mem_tag,
    input  logic          mem_bsy,
    input  logic          mem_rvalid,
    input  logic [W-1:0]  mem_rdata
`ifdef ARB_WRR_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_grant_0,
    output logic [15:0]   stat_grant_1,
    output logic [15:0]   stat_grant_2,
    output logic [15:0]   stat_grant_3
`endif
);

    localparam int PW = $clog2(RD);     // ID FIFO pointer width
    localparam int CW = PW + 1;         // ID FIFO occupancy width

    // ------------------------------------------------------------------
    // Per-client views of the flat port list
    // ------------------------------------------------------------------
    logic [3:0]    req_w;
    logic [3:0]    read_w;
    logic [AW-1:0] addr_w   [4];
    logic [W-1:0]  wdata_w  [4];
    logic [TW-1:0] tag_w    [4];
    logic [QW-1:0] weight_w [4];
    logic [QW-1:0] quota_w  [4];
    logic [3:0]    acc_w;
    logic [3:0]    rvalid_w;

    assign req_w  = {client_req_3, client_req_2, client_req_1, client_req_0};
    assign read_w = {client_read_3, client_read_2, client_read_1, client_read_0};

    assign addr_w[0]   = client_addr_0;
    assign addr_w[1]   = client_addr_1;
    assign addr_w[2]   = client_addr_2;
    assign addr_w[3]   = client_addr_3;
    assign wdata_w[0]  = client_wdata_0;
    assign wdata_w[1]  = client_wdata_1;
    assign wdata_w[2]  = client_wdata_2;
    assign wdata_w[3]  = client_wdata_3;
    assign tag_w[0]    = client_tag_0;
    assign tag_w[1]    = client_tag_1;
    assign tag_w[2]    = client_tag_2;
    assign tag_w[3]    = client_tag_3;
    assign weight_w[0] = cfg_weight_0;
    assign weight_w[1] = cfg_weight_1;
    assign weight_w[2] = cfg_weight_2;
    assign weight_w[3] = cfg_weight_3;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]    owner_q, owner_d;
    logic [QW-1:0] cnt_q,   cnt_d;
    logic          mem_req_q,   mem_req_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic          mem_read_q,  mem_read_d;
    logic [W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [TW-1:0] mem_tag_q,   mem_tag_d;

    logic [1:0]    rdq_mem_q [RD];
    logic [PW-1:0] rdq_wr_q, rdq_wr_d;
    logic [PW-1:0] rdq_rd_q, rdq_rd_d;
    logic [CW-1:0] rdq_cnt_q, rdq_cnt_d;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    logic       stay_w;
    logic [1:0] sel_w;
    logic [1:0] cand_w;
    logic       found_w;
    logic       slot_free_w;
    logic       rdq_full_w;
    logic       acc_any_w;
    logic       push_w;
    logic       pop_w;
    logic [1:0] head_w;

    // Zero weight behaves as a quota of one.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quota
            assign quota_w[gi] = (weight_w[gi] == '0) ? QW'(1) : weight_w[gi];
        end
    endgenerate

    // cnt == 0 only occurs after reset and means "no turn in progress",
    // so the very first search begins at owner+1 = client 0.
    always_comb begin
        stay_w  = req_w[owner_q] && (cnt_q != '0) && (cnt_q < quota_w[owner_q]);
        sel_w   = owner_q;
        cand_w  = '0;
        found_w = 1'b0;
        if (!stay_w) begin
            // Scan owner+1 .. owner+4; the 2-bit wrap puts owner last.
            for (int k = 1; k <= 4; k++) begin
                cand_w = owner_q + 2'(k);
                if (!found_w && req_w[cand_w]) begin
                    sel_w   = cand_w;
                    found_w = 1'b1;
                end
            end
        end
    end

    assign slot_free_w = ~mem_req_q | ~mem_bsy;
    // Full is taken from the registered count: a pop this cycle does not
    // make room for a push in the same cycle.
    assign rdq_full_w  = (rdq_cnt_q == CW'(RD));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_accept
            assign acc_w[gi] = req_w[gi] & (sel_w == 2'(gi)) & slot_free_w &
                               ~(read_w[gi] & rdq_full_w);
        end
    endgenerate

    assign acc_any_w = |acc_w;
    assign push_w    = acc_any_w & read_w[sel_w];
    // A return with no outstanding read is dropped.
    assign pop_w     = mem_rvalid & (rdq_cnt_q != '0);
    assign head_w    = rdq_mem_q[rdq_rd_q];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rvalid
            assign rvalid_w[gi] = pop_w & (head_w == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = mem_read_q;
        mem_wdata_d = mem_wdata_q;
        mem_tag_d   = mem_tag_q;
        if (acc_any_w) begin
            mem_req_d   = 1'b1;
            mem_addr_d  = addr_w[sel_w];
            mem_read_d  = read_w[sel_w];
            mem_wdata_d = wdata_w[sel_w];
            mem_tag_d   = tag_w[sel_w];
            if (stay_w) begin
                cnt_d = cnt_q + QW'(1);
            end else begin
                // New turn, including a single requester wrapping to itself.
                owner_d = sel_w;
                cnt_d   = QW'(1);
            end
        end else if (!mem_bsy) begin
            mem_req_d = 1'b0;
        end
    end

    always_comb begin
        rdq_wr_d  = rdq_wr_q + (push_w ? PW'(1) : PW'(0));
        rdq_rd_d  = rdq_rd_q + (pop_w  ? PW'(1) : PW'(0));
        rdq_cnt_d = rdq_cnt_q + CW'(push_w) - CW'(pop_w);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= 2'd3;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_tag_q   <= '0;
            rdq_wr_q    <= '0;
            rdq_rd_q    <= '0;
            rdq_cnt_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_wdata_q <= mem_wdata_d;
            mem_tag_q   <= mem_tag_d;
            rdq_wr_q    <= rdq_wr_d;
            rdq_rd_q    <= rdq_rd_d;
            rdq_cnt_q   <= rdq_cnt_d;
        end
    end

    // ID storage needs no reset: entries are only read while occupied.
    always_ff @(posedge clk) begin
        if (push_w) begin
            rdq_mem_q[rdq_wr_q] <= sel_w;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_tag   = mem_tag_q;

    assign client_bsy_0 = ~acc_w[0];
    assign client_bsy_1 = ~acc_w[1];
    assign client_bsy_2 = ~acc_w[2];
    assign client_bsy_3 = ~acc_w[3];

    assign client_rvalid_0 = rvalid_w[0];
    assign client_rvalid_1 = rvalid_w[1];
    assign client_rvalid_2 = rvalid_w[2];
    assign client_rvalid_3 = rvalid_w[3];

    assign client_rdata_0 = mem_rdata;
    assign client_rdata_1 = mem_rdata;
    assign client_rdata_2 = mem_rdata;
    assign client_rdata_3 = mem_rdata;

`ifdef ARB_WRR_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-client grant counters
    // ------------------------------------------------------------------
    logic [15:0] stat_q [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stats
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stat_q[gi] <= '0;
                end else if (stat_clr) begin
                    stat_q[gi] <= '0;
                end else if (acc_w[gi] && (stat_q[gi] != 16'hFFFF)) begin
                    stat_q[gi] <= stat_q[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_grant_0 = stat_q[0];
    assign stat_grant_1 = stat_q[1];
    assign stat_grant_2 = stat_q[2];
    assign stat_grant_3 = stat_q[3];
`endif

endmodule
`default_nettype wire
